// File: rtl/ram_block_mover_if.sv
// Command and RAM-port signal bundle for ram_block_mover.
// slave = the mover's view; master = the commanding side plus the RAM read-data return.
interface ram_block_mover_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 16
);
    logic              start;
    logic              op;
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    logic [ADDR_W-1:0] len;
    logic [DATA_W-1:0] fill_val;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] ram_address;
    logic              ram_load;
    logic [DATA_W-1:0] ram_in;
    logic [DATA_W-1:0] ram_out;

    modport slave (
        input  start, op, src, dst, len, fill_val, ram_out,
        output busy, done, ram_address, ram_load, ram_in
    );

    modport master (
        output start, op, src, dst, len, fill_val, ram_out,
        input  busy, done, ram_address, ram_load, ram_in
    );
endinterface

// File: rtl/ram_block_mover.sv
// Block FILL / COPY (memmove-safe) engine driving a 1-cycle-read RAM port while busy.
// FILL: 1 word/cycle, COPY: 2 cycles/word; done pulses the cycle after the last write.
module ram_block_mover #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    ram_block_mover_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, FILL, RD, WR} state_t;

    localparam logic OP_COPY = 1'b0;

    state_t            state_q;
    logic [ADDR_W-1:0] src_q, dst_q, idx_q, cnt_q;
    logic              desc_q;
    logic              busy_q, done_q, load_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] in_q;

    logic              cmd_desc;
    logic [ADDR_W-1:0] first_idx_d;
    logic [ADDR_W-1:0] idx_d;

    // Descend when the destination sits above the source so overlapping ranges survive.
    assign cmd_desc    = (bus.op == OP_COPY) && (bus.dst > bus.src);
    assign first_idx_d = cmd_desc ? (bus.len - ADDR_W'(1)) : '0;
    assign idx_d       = desc_q ? (idx_q - ADDR_W'(1)) : (idx_q + ADDR_W'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            desc_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            load_q  <= 1'b0;
            addr_q  <= '0;
            in_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        src_q  <= bus.src;
                        dst_q  <= bus.dst;
                        desc_q <= cmd_desc;
                        idx_q  <= first_idx_d;
                        cnt_q  <= bus.len - ADDR_W'(1);
                        if (bus.len == '0) begin
                            done_q <= 1'b1;
                        end else if (bus.op != OP_COPY) begin
                            state_q <= FILL;
                            busy_q  <= 1'b1;
                            addr_q  <= bus.dst + first_idx_d;
                            load_q  <= 1'b1;
                            in_q    <= bus.fill_val;
                        end else begin
                            state_q <= RD;
                            busy_q  <= 1'b1;
                            addr_q  <= bus.src + first_idx_d;
                            load_q  <= 1'b0;
                        end
                    end
                end
                FILL, WR: begin
                    if (cnt_q == '0) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        load_q  <= 1'b0;
                        addr_q  <= '0;
                        in_q    <= '0;
                    end else begin
                        idx_q <= idx_d;
                        cnt_q <= cnt_q - ADDR_W'(1);
                        if (state_q == FILL) begin
                            addr_q <= dst_q + idx_d;
                        end else begin
                            state_q <= RD;
                            addr_q  <= src_q + idx_d;
                            load_q  <= 1'b0;
                        end
                    end
                end
                RD: begin
                    state_q <= WR;
                    addr_q  <= dst_q + idx_q;
                    load_q  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.ram_address = addr_q;
    assign bus.ram_load    = load_q;
    // Read data only arrives in the WR cycle itself, so it bypasses the output register.
    assign bus.ram_in      = (state_q == WR) ? bus.ram_out : in_q;
endmodule
